frame_serializer: RTL

Transmit-side counterpart of the six-byte parallel summer/averager. Accepts one 48-bit word {F,E,D,C,B,A} through a valid/ready handshake. Emits it as a byte stream, byte A first, followed by a two-byte trailer carrying the 11-bit byte sum. It also reports that sum and sum/4 on completion, so the receiving end can check its own result against the one produced here.

---
 rtl/frame_serializer_pkg.sv | 32 +++
 rtl/frame_accumulator.sv | 48 ++++
 rtl/frame_serializer.sv | 116 +++++++++++
 3 files changed

// File: rtl/frame_serializer_pkg.sv
// Shared definitions for the six-byte frame serializer and its summer/averager peer:
// byte/frame/sum widths, FSM state encoding and small arithmetic helpers.
package frame_serializer_pkg;

  localparam int BYTE_W  = 8;
  localparam int FRAME_W = 48;
  localparam int SUM_W   = 11;
  localparam int N_BYTES = 6;
  localparam int CNT_W   = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_SUM_LO = 2'd2;
  localparam logic [1:0] S_SUM_HI = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = S_IDLE,
    DATA   = S_DATA,
    SUM_LO = S_SUM_LO,
    SUM_HI = S_SUM_HI
  } state_t;

  // Zero-extend a stream byte to accumulator width.
  function automatic logic [SUM_W-1:0] widen(input logic [BYTE_W-1:0] b);
    return {{(SUM_W-BYTE_W){1'b0}}, b};
  endfunction

  function automatic logic [SUM_W-1:0] avg_of(input logic [SUM_W-1:0] s);
    return s >> 2'd2;
  endfunction

endpackage

// File: rtl/frame_accumulator.sv
// Running byte-sum accumulator with clear/enable, plus the sum and sum/4 results
// latched when a frame completes.
module frame_accumulator
  import frame_serializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic              commit,
  input  logic [BYTE_W-1:0] add_byte,
  output logic [SUM_W-1:0]  acc,
  output logic [SUM_W-1:0]  sum,
  output logic [SUM_W-1:0]  avg
);

  logic [SUM_W-1:0] acc_next;

  // Next accumulator value; 11 bits cannot overflow for six bytes.
  always_comb begin
    acc_next = acc + widen(add_byte);
  end

  // Accumulator and committed results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= {SUM_W{1'b0}};
      sum <= {SUM_W{1'b0}};
      avg <= {SUM_W{1'b0}};
    end else begin
      if (clear) begin
        acc <= {SUM_W{1'b0}};
      end else if (en) begin
        acc <= acc_next;
      end else begin
        acc <= acc;
      end
      if (commit) begin
        sum <= acc;
        avg <= avg_of(acc);
      end else begin
        sum <= sum;
        avg <= avg;
      end
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Serializes one 48-bit frame as six data bytes (A first) followed by a two-byte
// sum trailer; reports the sum and sum/4 of each completed frame.
module frame_serializer
  import frame_serializer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [FRAME_W-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [BYTE_W-1:0]  out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               done,
  output logic [SUM_W-1:0]   sum,
  output logic [SUM_W-1:0]   avg
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

  state_t             state;
  logic [FRAME_W-1:0] shift;
  logic [CNT_W-1:0]   cnt;
  logic [SUM_W-1:0]   acc;
  logic               accept;
  logic               hs;
  logic               byte_en;
  logic               commit;
  logic [BYTE_W-1:0]  sum_lo_next;

  assign accept  = in_valid & in_ready;
  assign hs      = out_valid & out_ready;
  assign byte_en = hs & (state == DATA);
  assign commit  = hs & (state == SUM_HI);
  // Low trailer byte is the 8-bit wrap of acc + last data byte.
  assign sum_lo_next = acc[BYTE_W-1:0] + shift[BYTE_W-1:0];

  frame_accumulator u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .en       (byte_en),
    .commit   (commit),
    .add_byte (shift[BYTE_W-1:0]),
    .acc      (acc),
    .sum      (sum),
    .avg      (avg)
  );

  // Control FSM; all stream outputs are loaded one step ahead so they are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= {FRAME_W{1'b0}};
      cnt       <= {CNT_W{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= {BYTE_W{1'b0}};
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift     <= in_data;
            cnt       <= {CNT_W{1'b0}};
            state     <= DATA;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= in_data[BYTE_W-1:0];
            out_last  <= 1'b0;
          end
        end
        DATA: begin
          if (hs) begin
            shift <= {{BYTE_W{1'b0}}, shift[FRAME_W-1:BYTE_W]};
            cnt   <= cnt + CNT_W'(1);
            if (cnt == LAST_IDX) begin
              state    <= SUM_LO;
              out_data <= sum_lo_next;
            end else begin
              out_data <= shift[2*BYTE_W-1:BYTE_W];
            end
          end
        end
        SUM_LO: begin
          if (hs) begin
            state    <= SUM_HI;
            out_data <= {{(2*BYTE_W-SUM_W){1'b0}}, acc[SUM_W-1:BYTE_W]};
            out_last <= 1'b1;
          end
        end
        SUM_HI: begin
          if (hs) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= {BYTE_W{1'b0}};
            out_last  <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_data  <= {BYTE_W{1'b0}};
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
